fpadd_sched: RTL and testbench

Shares one single-precision floating-point adder datapath (operand pair in, 32-bit sum out, fixed latency) among several requesters. Arbitrates round-robin, registers the winning operand pair, holds it on the adder for a fixed number of cycles, captures the sum and returns it to the originating requester over a valid/ready response channel. Sits between client blocks and the adder top; one operation is in flight at a time.

---
 rtl/fpadd_pkg.sv | 23 ++
 rtl/fpadd_sched_if.sv | 31 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/fpadd_sched.sv | 98 +++++++++
 tb/tb_fpadd_sched.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpadd_pkg.sv
// Shared types for the floating-point adder scheduler: word width, FSM
// state encoding, operand-pair payload and an index-width helper.
package fpadd_pkg;

  localparam int unsigned FP_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
  } fp_pair_t;

  // Width of an index over n items, never below one bit
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/fpadd_sched_if.sv
// Request/response and adder-side bundle for the adder scheduler.
// The slave modport is the scheduler; master is the client/adder environment.
interface fpadd_sched_if
  import fpadd_pkg::*;
#(
  parameter int unsigned N_REQ = 2
);

  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ*FP_W-1:0] req_a;
  logic [N_REQ*FP_W-1:0] req_b;
  logic [N_REQ-1:0]      resp_valid;
  logic [N_REQ-1:0]      resp_ready;
  logic [FP_W-1:0]       resp_res;
  logic [FP_W-1:0]       add_a;
  logic [FP_W-1:0]       add_b;
  logic [FP_W-1:0]       add_res;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b, resp_ready, add_res,
    input  req_ready, resp_valid, resp_res, add_a, add_b, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready, add_res,
    output req_ready, resp_valid, resp_res, add_a, add_b, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or above ptr,
// wrapping modulo N. Produces one-hot grant, its index and an any flag.
module rr_arbiter
  import fpadd_pkg::*;
#(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    logic [31:0] j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!any && req[IW'(j)]) begin
        any = 1'b1;
        idx = IW'(j);
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/fpadd_sched.sv
// Time-shares one fixed-latency FP adder among N_REQ requesters: round-robin
// accept, hold operands for ADD_LAT cycles, return the sum to the owner.
module fpadd_sched
  import fpadd_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned ADD_LAT = 2
) (
  input logic          clk,
  input logic          rst_n,
  fpadd_sched_if.slave bus
);

  localparam int unsigned IW = idx_w(N_REQ);
  localparam int unsigned CW = idx_w(ADD_LAT);

  sched_state_t    state, state_n;
  logic [IW-1:0]   rr_ptr, owner, gnt_idx;
  logic [CW-1:0]   lat_cnt;
  logic [N_REQ-1:0] gnt;
  logic            gnt_any, accept;
  fp_pair_t        op;
  logic [FP_W-1:0] res_q;
  logic [FP_W-1:0] a_arr [N_REQ];
  logic [FP_W-1:0] b_arr [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_slice
    assign a_arr[k] = bus.req_a[k*FP_W +: FP_W];
    assign b_arr[k] = bus.req_b[k*FP_W +: FP_W];
  end

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign accept = (state == IDLE) && gnt_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (gnt_any) state_n = WAIT;
      WAIT:    if (lat_cnt == '0) state_n = RESP;
      RESP:    if (bus.resp_ready[owner]) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Grant is only offered while idle; response only to the owner
  always_comb begin
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    bus.busy       = 1'b1;
    case (state)
      IDLE: begin
        bus.req_ready = gnt;
        bus.busy      = 1'b0;
      end
      RESP:    bus.resp_valid[owner] = 1'b1;
      default: ;
    endcase
  end

  assign bus.add_a    = op.a;
  assign bus.add_b    = op.b;
  assign bus.resp_res = res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      owner   <= '0;
      lat_cnt <= '0;
      op      <= '0;
      res_q   <= '0;
    end else begin
      if (accept) begin
        op      <= '{a: a_arr[gnt_idx], b: b_arr[gnt_idx]};
        owner   <= gnt_idx;
        rr_ptr  <= (32'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + IW'(1);
        lat_cnt <= CW'(ADD_LAT - 1);
      end
      // add_res is only meaningful on the last WAIT cycle
      if (state == WAIT) begin
        if (lat_cnt == '0) res_q <= bus.add_res;
        else               lat_cnt <= lat_cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fpadd_sched.sv
// Directed bench for fpadd_sched: a 2-requester/ADD_LAT=2 instance plus
// 4-requester sweeps at ADD_LAT=1 and ADD_LAT=15, each with a pipelined adder model.
module tb_fpadd_sched;

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
  } vec_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic rst1_n = 1'b0;
  logic rst2_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  int sel   = 0;

  logic [1:0]   m_valid = '0, m_rr = '1;
  logic [63:0]  m_a = '0, m_b = '0;
  logic [3:0]   s_valid = '0, s_rr = '1;
  logic [127:0] s_a = '0, s_b = '0;

  fpadd_sched_if #(.N_REQ(2)) if0 ();
  fpadd_sched_if #(.N_REQ(4)) if1 ();
  fpadd_sched_if #(.N_REQ(4)) if2 ();

  fpadd_sched #(.N_REQ(2), .ADD_LAT(2))  u0 (.clk(clk), .rst_n(rst_n),  .bus(if0.slave));
  fpadd_sched #(.N_REQ(4), .ADD_LAT(1))  u1 (.clk(clk), .rst_n(rst1_n), .bus(if1.slave));
  fpadd_sched #(.N_REQ(4), .ADD_LAT(15)) u2 (.clk(clk), .rst_n(rst2_n), .bus(if2.slave));

  assign if0.req_valid = m_valid;  assign if0.req_a = m_a;  assign if0.req_b = m_b;
  assign if0.resp_ready = m_rr;
  assign if1.req_valid = s_valid;  assign if1.req_a = s_a;  assign if1.req_b = s_b;
  assign if1.resp_ready = s_rr;
  assign if2.req_valid = s_valid;  assign if2.req_a = s_a;  assign if2.req_b = s_b;
  assign if2.resp_ready = s_rr;

  // Known single-precision sums for the operand pairs used here; NaN otherwise
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000;
      {32'h3FC00000, 32'h3F800000}: return 32'h40200000;
      {32'h3F800000, 32'hBF800000}: return 32'h00000000;
      {32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {32'h40000000, 32'h3F800000}: return 32'h40400000;
      {32'h40400000, 32'h3F800000}: return 32'h40800000;
      {32'h40800000, 32'h3F800000}: return 32'h40A00000;
      default:                      return 32'h7FC00000;
    endcase
  endfunction

  function automatic logic [31:0] fl(input int k);
    case (k)
      1:       return 32'h3F800000;
      2:       return 32'h40000000;
      3:       return 32'h40400000;
      4:       return 32'h40800000;
      5:       return 32'h40A00000;
      default: return 32'h7FC00000;
    endcase
  endfunction

  function automatic int lsb_idx(input logic [7:0] v);
    int r = 0;
    for (int i = 7; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // Adder models: result valid ADD_LAT cycles after operands settle
  logic [31:0] a0_q;
  logic [31:0] a2_q [14];
  always_ff @(posedge clk) begin
    a0_q     <= fadd(if0.add_a, if0.add_b);
    a2_q[0]  <= fadd(if2.add_a, if2.add_b);
    for (int i = 1; i < 14; i++) a2_q[i] <= a2_q[i-1];
  end
  assign if0.add_res = a0_q;
  assign if1.add_res = fadd(if1.add_a, if1.add_b);
  assign if2.add_res = a2_q[13];

  logic [7:0]  v_req_ready, v_resp_valid;
  logic [31:0] v_resp_res;
  logic        v_busy;
  always_comb begin
    v_req_ready = '0; v_resp_valid = '0; v_resp_res = '0; v_busy = 1'b0;
    case (sel)
      0: begin
        v_req_ready = 8'(if0.req_ready); v_resp_valid = 8'(if0.resp_valid);
        v_resp_res  = if0.resp_res;      v_busy       = if0.busy;
      end
      1: begin
        v_req_ready = 8'(if1.req_ready); v_resp_valid = 8'(if1.resp_valid);
        v_resp_res  = if1.resp_res;      v_busy       = if1.busy;
      end
      default: begin
        v_req_ready = 8'(if2.req_ready); v_resp_valid = 8'(if2.resp_valid);
        v_resp_res  = if2.resp_res;      v_busy       = if2.busy;
      end
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_acc(input string tag, output int c);
    bit ok = 1'b0;
    c = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (v_req_ready != 8'h00) begin ok = 1'b1; c = cyc; end
    end
    n_chk++;
    if (!ok) begin n_err++; $display("FAIL %s_accept: no grant within 40 cycles", tag); end
  endtask

  task automatic wait_resp(input string tag, output int c);
    bit ok = 1'b0;
    c = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (v_resp_valid != 8'h00) begin ok = 1'b1; c = cyc; end
    end
    n_chk++;
    if (!ok) begin n_err++; $display("FAIL %s_resp: no response within 40 cycles", tag); end
  endtask

  task automatic run_op(input string tag, input vec_t v);
    int ca, cr;
    @(posedge clk); #1;
    m_a[32*v.r +: 32] = v.a;
    m_b[32*v.r +: 32] = v.b;
    m_valid[v.r]      = 1'b1;
    wait_acc(tag, ca);
    chk({tag, "_grant"}, 64'(v_req_ready), 64'(1) << v.r);
    @(posedge clk); #1;
    m_valid = '0;
    wait_resp(tag, cr);
    chk({tag, "_lat"},   64'(cr - ca), 64'd3);
    chk({tag, "_valid"}, 64'(v_resp_valid), 64'(1) << v.r);
    chk({tag, "_res"},   64'(v_resp_res), 64'(v.sum));
    @(negedge clk);
    chk({tag, "_idle"},  64'(v_busy), 64'd0);
  endtask

  task automatic sweep(input string tag, input int lat);
    int ca, cr, prev, g;
    int served [4];
    served = '{default: 0};
    prev   = 0;
    for (int k = 0; k < 8; k++) begin
      wait_acc(tag, ca);
      g = lsb_idx(v_req_ready);
      chk({tag, "_grant"}, 64'(v_req_ready), 64'(1) << (k % 4));
      if (k > 0) chk({tag, "_gap"}, 64'(ca - prev), 64'(lat + 2));
      prev = ca;
      if (k == 7) begin @(posedge clk); #1; s_valid = '0; end
      wait_resp(tag, cr);
      chk({tag, "_lat"},   64'(cr - ca), 64'(lat + 1));
      chk({tag, "_valid"}, 64'(v_resp_valid), 64'(1) << g);
      chk({tag, "_res"},   64'(v_resp_res), 64'(fl(g + 2)));
      if (g < 4) served[g]++;
    end
    for (int i = 0; i < 4; i++) chk({tag, "_served"}, 64'(served[i]), 64'd2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs [5];
    int   ca, cr, prev, rel;
    vecs[0] = '{r: 0, a: 32'h3F800000, b: 32'h40000000, sum: 32'h40400000};
    vecs[1] = '{r: 1, a: 32'h3FC00000, b: 32'h3F800000, sum: 32'h40200000};
    vecs[2] = '{r: 0, a: 32'h3F800000, b: 32'hBF800000, sum: 32'h00000000};
    vecs[3] = '{r: 1, a: 32'h40000000, b: 32'h3F800000, sum: 32'h40400000};
    vecs[4] = '{r: 1, a: 32'h3F800000, b: 32'h3F800000, sum: 32'h40000000};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_busy",       64'(if0.busy), 64'd0);
    chk("rst_resp_valid", 64'(if0.resp_valid), 64'd0);
    chk("rst_req_ready",  64'(if0.req_ready), 64'd0);
    chk("rst_add_ops",    {if0.add_a, if0.add_b}, 64'd0);
    chk("rst_resp_res",   64'(if0.resp_res), 64'd0);

    // Contention from reset: alternating grants, back-to-back
    @(posedge clk); #1;
    m_a = {32'h3F800000, 32'h3FC00000};
    m_b = {32'hBF800000, 32'h3F800000};
    m_valid = 2'b11;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rel   = cyc;
    prev  = 0;
    for (int k = 0; k < 4; k++) begin
      wait_acc("cont", ca);
      chk("cont_grant", 64'(v_req_ready), 64'(1) << (k % 2));
      if (k == 0) chk("cont_first", 64'(ca - rel), 64'd0);
      else        chk("cont_gap",   64'(ca - prev), 64'd4);
      prev = ca;
      if (k == 3) begin @(posedge clk); #1; m_valid = '0; end
      wait_resp("cont", cr);
      chk("cont_lat",   64'(cr - ca), 64'd3);
      chk("cont_valid", 64'(v_resp_valid), 64'(1) << (k % 2));
      chk("cont_res",   64'(v_resp_res), (k % 2 == 0) ? 64'h40200000 : 64'h0);
    end

    for (int i = 0; i < 5; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Response stall with a second request pending
    @(posedge clk); #1;
    m_rr = 2'b00;
    m_a[31:0] = 32'h3F800000; m_b[31:0] = 32'h3F800000;
    m_valid = 2'b01;
    wait_acc("stall", ca);
    chk("stall_grant", 64'(v_req_ready), 64'h1);
    @(posedge clk); #1;
    m_a[63:32] = 32'h40400000; m_b[63:32] = 32'h3F800000;
    m_valid = 2'b10;
    wait_resp("stall", cr);
    chk("stall_lat", 64'(cr - ca), 64'd3);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_hold", {16'h0, v_resp_valid, v_req_ready, v_resp_res},
          {16'h0, 8'h01, 8'h00, 32'h40000000});
    end

    // Owner 1 in RESP, only resp_ready[0] asserted
    @(posedge clk); #1;
    m_rr = 2'b01;
    wait_acc("wport", ca);
    chk("wport_grant", 64'(v_req_ready), 64'h2);
    @(posedge clk); #1;
    m_valid = '0;
    wait_resp("wport", cr);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("wport_hold", {23'h0, v_busy, v_resp_valid, v_resp_res},
          {23'h0, 1'b1, 8'h02, 32'h40800000});
    end
    @(posedge clk); #1;
    m_rr = 2'b10;
    repeat (2) @(negedge clk);
    chk("wport_release", {v_busy, v_resp_valid}, {1'b0, 8'h00});
    m_rr = 2'b11;

    // Asynchronous reset in the first WAIT cycle
    @(posedge clk); #1;
    m_a[31:0] = 32'h3F800000; m_b[31:0] = 32'h40000000;
    m_valid = 2'b01;
    wait_acc("rstw", ca);
    @(posedge clk); #1;
    m_valid = '0;
    rst_n   = 1'b0;
    #1;
    chk("rstw_busy",       64'(if0.busy), 64'd0);
    chk("rstw_resp_valid", 64'(if0.resp_valid), 64'd0);
    chk("rstw_add_ops",    {if0.add_a, if0.add_b}, 64'd0);
    chk("rstw_resp_res",   64'(if0.resp_res), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op("rstw_after", vecs[3]);

    // Four requesters, continuously valid, ADD_LAT 1 then 15
    s_a = {fl(4), fl(3), fl(2), fl(1)};
    s_b = {4{32'h3F800000}};
    sel = 1;
    @(posedge clk); #1;
    s_valid = 4'hF;
    rst1_n  = 1'b1;
    sweep("sw1", 1);
    @(posedge clk); #1;
    rst1_n  = 1'b0;
    sel     = 2;
    s_valid = 4'hF;
    rst2_n  = 1'b1;
    sweep("sw15", 15);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
